// File: rtl/mux4_rr_arbiter_pkg.sv
// ============================================================================
// Module   : mux4_rr_arbiter_pkg
// Brief    : Shared state encodings, sizing constants and the round-robin
//            priority search for the mux4 round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux4_rr_arbiter_pkg;

  localparam int N_REQ            = 4;
  localparam int HOLD_MAX_DEFAULT = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // First set request strictly after ptr, wrapping; ptr itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] result;
    logic       found;
    result = ptr;
    found  = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        result = idx;
        found  = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux4.sv
// ============================================================================
// Module   : mux4
// Brief    : Gate-level 4:1 single-bit multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4 (
  input  logic [3:0] in,
  input  logic [1:0] select,
  output logic       out
);

  logic [1:0] w_sel_n;
  logic [3:0] w_term;

  not u_inv0 (w_sel_n[0], select[0]);
  not u_inv1 (w_sel_n[1], select[1]);

  and u_and0 (w_term[0], in[0], w_sel_n[1], w_sel_n[0]);
  and u_and1 (w_term[1], in[1], w_sel_n[1], select[0]);
  and u_and2 (w_term[2], in[2], select[1],  w_sel_n[0]);
  and u_and3 (w_term[3], in[3], select[1],  select[0]);

  or  u_or   (out, w_term[0], w_term[1], w_term[2], w_term[3]);

endmodule

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
// Module   : mux4_rr_arbiter
// Brief    : Round-robin arbiter sharing one mux4 among four requesters, with
//            bounded hold and a registered data/valid output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] data_in,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic       data_out,
  output logic       valid
);

  localparam logic [3:0] C_CNT_LAST = 4'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] select_q, select_d;
  logic       data_out_q, data_out_d;
  logic       valid_q, valid_d;

  logic [1:0] w_pick;
  logic       w_mux_out;

  assign w_pick = rr_pick(req, ptr_q);

  mux4 u_mux4 (
    .in     (data_in),
    .select (select_q),
    .out    (w_mux_out)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    select_d   = select_q;
    data_out_d = data_out_q;
    valid_d    = valid_q;
    case (state_q)
      ST_IDLE: begin
        grant_d = 4'b0000;
        valid_d = 1'b0;
        if (|req) begin
          grant_d  = 4'b0001 << w_pick;
          select_d = w_pick;
          ptr_d    = w_pick;
          cnt_d    = 4'd0;
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        data_out_d = w_mux_out;
        valid_d    = 1'b1;
        // Release leaves a bubble: the IDLE cycle does the next arbitration.
        if (!req[select_q] || (cnt_q == C_CNT_LAST)) begin
          grant_d = 4'b0000;
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        grant_d = 4'b0000;
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 2'd3;
      cnt_q      <= 4'd0;
      grant_q    <= 4'b0000;
      select_q   <= 2'd0;
      data_out_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      select_q   <= select_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

  assign grant    = grant_q;
  assign select   = select_q;
  assign data_out = data_out_q;
  assign valid    = valid_q;

endmodule

`default_nettype wire
